// File: rtl/jpeg_idct_pkg.sv
// Shared types for the IDCT transpose block buffer: bank lifecycle states,
// block geometry and the column-major read address mapping.
package jpeg_idct_pkg;

   localparam int unsigned BLK_ENTRIES = 64;
   localparam int unsigned ROW_W       = 3;

   typedef logic [5:0] blk_idx_t;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_e;

   // Output sequence number -> RAM address: swap row and column fields.
   function automatic blk_idx_t transpose_idx(input blk_idx_t seq);
      return {seq[ROW_W-1:0], seq[5:ROW_W]};
   endfunction

endpackage

// File: rtl/jpeg_idct_block_ram.sv
// One 64-entry bank of the transpose buffer: synchronous RAM with one write
// port and one read-first read port (1-cycle read latency).
module jpeg_idct_block_ram
   import jpeg_idct_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              wr_en,
   input  blk_idx_t          wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  blk_idx_t          rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [BLK_ENTRIES];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/jpeg_idct_block_buf.sv
// Ping-pong 8x8 block buffer transposing between IDCT passes.
// Optional synchronous flush port enabled by `JPEG_IDCT_BUF_FLUSH_EN.
module jpeg_idct_block_buf
   import jpeg_idct_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IDX_W  = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inport_valid_i,
   input  logic [DATA_W-1:0] inport_data_i,
   input  logic [IDX_W-1:0]  inport_idx_i,
   input  logic              inport_last_i,
   output logic              inport_accept_o,
   output logic              outport_valid_o,
   output logic [DATA_W-1:0] outport_data_o,
   output logic [IDX_W-1:0]  outport_idx_o,
   output logic              outport_last_o,
   input  logic              outport_accept_i
`ifdef JPEG_IDCT_BUF_FLUSH_EN
   ,
   input  logic              flush_i
`endif
);

   bank_state_e       bank_q [2];
   bank_state_e       bank_d [2];
   logic              wr_bank_q;
   logic              rd_bank_q;
   blk_idx_t          rd_cnt_q;
   logic              rd_pend_q;
   logic              rd_pend_bank_q;
   blk_idx_t          rd_pend_idx_q;

   logic [DATA_W-1:0] sk_data_q [2];
   blk_idx_t          sk_idx_q  [2];
   logic              sk_bank_q [2];
   logic              sk_rptr_q;
   logic              sk_wptr_q;
   logic [1:0]        sk_cnt_q;

   logic              flush;
   logic              wr_fire;
   logic              out_fire;
   logic              pop_last;
   logic              rd_issue;
   logic [1:0]        occ;
   blk_idx_t          rd_addr;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] ram_rdata;

`ifdef JPEG_IDCT_BUF_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   assign rd_addr   = transpose_idx(rd_cnt_q);
   assign ram_rdata = rd_pend_bank_q ? rdata1 : rdata0;

   jpeg_idct_block_ram #(.DATA_W(DATA_W)) u_ram0 (
      .clk     (clk_i),
      .wr_en   (wr_fire && !wr_bank_q),
      .wr_addr (blk_idx_t'(inport_idx_i)),
      .wr_data (inport_data_i),
      .rd_en   (rd_issue && !rd_bank_q),
      .rd_addr (rd_addr),
      .rd_data (rdata0)
   );

   jpeg_idct_block_ram #(.DATA_W(DATA_W)) u_ram1 (
      .clk     (clk_i),
      .wr_en   (wr_fire && wr_bank_q),
      .wr_addr (blk_idx_t'(inport_idx_i)),
      .wr_data (inport_data_i),
      .rd_en   (rd_issue && rd_bank_q),
      .rd_addr (rd_addr),
      .rd_data (rdata1)
   );

   // Issue side runs ahead of the output: rd_bank/rd_cnt advance once all 64
   // reads are issued, while the bank only empties when its sample 63 leaves
   // the skid. This lets the next FULL bank start reading without a bubble.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned b = 0; b < 2; b++) bank_q[b] <= BANK_EMPTY;
         wr_bank_q      <= 1'b0;
         rd_bank_q      <= 1'b0;
         rd_cnt_q       <= '0;
         rd_pend_q      <= 1'b0;
         rd_pend_bank_q <= 1'b0;
         rd_pend_idx_q  <= '0;
      end else if (flush) begin
         for (int unsigned b = 0; b < 2; b++) bank_q[b] <= BANK_EMPTY;
         wr_bank_q      <= 1'b0;
         rd_bank_q      <= 1'b0;
         rd_cnt_q       <= '0;
         rd_pend_q      <= 1'b0;
         rd_pend_bank_q <= 1'b0;
         rd_pend_idx_q  <= '0;
      end else begin
         for (int unsigned b = 0; b < 2; b++) bank_q[b] <= bank_d[b];
         if (wr_fire && inport_last_i) wr_bank_q <= ~wr_bank_q;
         if (rd_issue) begin
            rd_cnt_q <= rd_cnt_q + 6'd1;
            if (rd_cnt_q == 6'd63) rd_bank_q <= ~rd_bank_q;
         end
         rd_pend_q      <= rd_issue;
         rd_pend_bank_q <= rd_bank_q;
         rd_pend_idx_q  <= rd_cnt_q;
      end
   end

   always_comb begin
      wr_fire  = inport_valid_i && inport_accept_o && !flush;
      out_fire = outport_valid_o && outport_accept_i;
      pop_last = out_fire && (sk_idx_q[sk_rptr_q] == 6'd63);
      // Skid occupancy after this cycle's pop, counting the read in flight.
      occ      = sk_cnt_q + {1'b0, rd_pend_q} - {1'b0, out_fire};
      rd_issue = ((bank_q[rd_bank_q] == BANK_FULL) ||
                  (bank_q[rd_bank_q] == BANK_DRAINING)) &&
                 (occ < 2'd2) && !flush;
      for (int unsigned b = 0; b < 2; b++) begin
         bank_d[b] = bank_q[b];
         if (wr_fire && (wr_bank_q == 1'(b))) begin
            bank_d[b] = inport_last_i ? BANK_FULL : BANK_FILLING;
         end
         if (rd_issue && (rd_bank_q == 1'(b)) && (bank_q[b] == BANK_FULL)) begin
            bank_d[b] = BANK_DRAINING;
         end
         if (pop_last && (sk_bank_q[sk_rptr_q] == 1'(b))) begin
            bank_d[b] = BANK_EMPTY;
         end
      end
   end

   always_comb begin
      inport_accept_o = (bank_q[wr_bank_q] == BANK_EMPTY) ||
                        (bank_q[wr_bank_q] == BANK_FILLING);
      outport_valid_o = (sk_cnt_q != 2'd0);
      outport_data_o  = '0;
      outport_idx_o   = '0;
      outport_last_o  = 1'b0;
      if (outport_valid_o) begin
         outport_data_o = sk_data_q[sk_rptr_q];
         outport_idx_o  = IDX_W'(sk_idx_q[sk_rptr_q]);
         outport_last_o = (sk_idx_q[sk_rptr_q] == 6'd63);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sk_rptr_q <= 1'b0;
         sk_wptr_q <= 1'b0;
         sk_cnt_q  <= '0;
      end else if (flush) begin
         sk_rptr_q <= 1'b0;
         sk_wptr_q <= 1'b0;
         sk_cnt_q  <= '0;
      end else begin
         if (rd_pend_q) begin
            sk_data_q[sk_wptr_q] <= ram_rdata;
            sk_idx_q[sk_wptr_q]  <= rd_pend_idx_q;
            sk_bank_q[sk_wptr_q] <= rd_pend_bank_q;
            sk_wptr_q            <= ~sk_wptr_q;
         end
         if (out_fire) sk_rptr_q <= ~sk_rptr_q;
         sk_cnt_q <= sk_cnt_q + {1'b0, rd_pend_q} - {1'b0, out_fire};
      end
   end

endmodule
